reg_op_sequencer: RTL and testbench

Command sequencer placed directly upstream of `super_register_8bits`. It accepts register commands over a valid/ready handshake, buffers them in a small FIFO, and drives the register's `operation`, `in_data`, `in_shift_right` and `in_shift_left` inputs one cycle at a time. Each command repeats its operation for a programmed number of cycles. A command can also end early when the register's `flag` output asserts. When no command is active, the block holds the register with `store`.

---
 rtl/reg_op_sequencer.sv | 127 ++++++++++++
 tb/tb_reg_op_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// rtl/reg_op_sequencer.sv - queued command sequencer driving super_register_8bits controls
module reg_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [7:0]               cmd_data,
    input  logic [3:0]               cmd_count,
    input  logic                     cmd_serial,
    input  logic                     cmd_stop_on_flag,
    input  logic                     reg_flag,
    output logic [2:0]               operation,
    output logic [7:0]               in_data,
    output logic                     in_shift_right,
    output logic                     in_shift_left,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [2:0] OP_STORE = 3'd5;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic [3:0] count;
        logic       serial;
        logic       stop;
    } cmd_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state, state_next;
    cmd_t            mem [DEPTH];
    cmd_t            head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [3:0]      remaining;
    logic            cur_stop;
    logic            push, pop, fifo_empty, last_cycle;

    assign cmd_ready  = (fill != FULL);
    assign fifo_empty = (fill == '0);
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];

    // Command storage; contents need no reset since fill gates every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{op: cmd_op, data: cmd_data, count: cmd_count,
                             serial: cmd_serial, stop: cmd_stop_on_flag};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: leave ISSUE only when the last cycle ends with nothing queued
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = ISSUE;
            ISSUE:   if (last_cycle && fifo_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: last-cycle detection includes the same-cycle flag for early stop
    always_comb begin
        busy       = (state == ISSUE);
        last_cycle = busy && ((remaining == '0) || (cur_stop && reg_flag));
        done       = last_cycle;
        pop        = !fifo_empty && ((state == IDLE) || last_cycle);
    end

    // Registered register-control outputs: load on pop, fall back to store when a command ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operation      <= OP_STORE;
            in_data        <= '0;
            in_shift_right <= 1'b0;
            in_shift_left  <= 1'b0;
            remaining      <= '0;
            cur_stop       <= 1'b0;
        end else if (pop) begin
            operation      <= head.op;
            in_data        <= head.data;
            in_shift_right <= (head.op == 3'd1) && head.serial;
            in_shift_left  <= (head.op == 3'd2) && head.serial;
            remaining      <= head.count;
            cur_stop       <= head.stop;
        end else if (last_cycle) begin
            operation      <= OP_STORE;
            in_data        <= '0;
            in_shift_right <= 1'b0;
            in_shift_left  <= 1'b0;
            remaining      <= '0;
            cur_stop       <= 1'b0;
        end else if (busy) begin
            remaining      <= remaining - 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb/tb_reg_op_sequencer.sv - self-checking bench for reg_op_sequencer
module tb_reg_op_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_count;
    logic       cmd_serial, cmd_stop_on_flag, reg_flag;
    logic [2:0] operation;
    logic [7:0] in_data;
    logic       in_shift_right, in_shift_left, busy, done;
    logic [2:0] fill;

    // Plant: behavioural super register driven by the DUT outputs
    logic [7:0] reg_val;
    assign reg_flag = (reg_val == 8'h00);

    always #5 clk = ~clk;

    reg_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .cmd_serial(cmd_serial), .cmd_stop_on_flag(cmd_stop_on_flag),
        .reg_flag(reg_flag), .operation(operation), .in_data(in_data),
        .in_shift_right(in_shift_right), .in_shift_left(in_shift_left),
        .busy(busy), .done(done), .fill(fill)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [3:0] count;
        logic       serial;
        logic       stop;
    } cmd_s;

    // Reference model: pending queue, active command and cycles left for it
    cmd_s q[$];
    cmd_s cur;
    bit   active;
    int   left;
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_apply(input logic [7:0] v, input logic [2:0] op,
                                             input logic [7:0] d, input logic sr, input logic sl);
        case (op)
            3'd0:    return d;
            3'd1:    return {sr, v[7:1]};
            3'd2:    return {v[6:0], sl};
            3'd3:    return {v[0], v[7:1]};
            3'd4:    return {v[6:0], v[7]};
            3'd6:    return v + 8'd1;
            3'd7:    return v - 8'd1;
            default: return v;
        endcase
    endfunction

    task automatic check_outputs();
        chk("operation", operation, active ? cur.op : 3'd5);
        chk("in_data",   in_data,   active ? cur.data : 8'h00);
        chk("shift_r",   in_shift_right, active && cur.op == 3'd1 && cur.serial);
        chk("shift_l",   in_shift_left,  active && cur.op == 3'd2 && cur.serial);
        chk("busy",      busy, active);
        chk("done",      done, active && (left == 1 || (cur.stop && reg_flag)));
        chk("fill",      fill, q.size());
        chk("cmd_ready", cmd_ready, q.size() < DEPTH);
        if (done === 1'b1) done_seen++;
    endtask

    // One clock: capture pre-edge inputs/outputs, advance plant and model, then compare
    task automatic step(output bit accepted);
        bit         push_now, flag_now, fin;
        cmd_s       nc;
        logic [7:0] nv;
        push_now = cmd_valid && (q.size() < DEPTH);
        flag_now = reg_flag;
        nc = '{op: cmd_op, data: cmd_data, count: cmd_count, serial: cmd_serial, stop: cmd_stop_on_flag};
        nv = reg_apply(reg_val, operation, in_data, in_shift_right, in_shift_left);
        fin = active && (left == 1 || (cur.stop && flag_now));
        @(posedge clk);
        #1;
        reg_val = nv;
        if (!active || fin) begin
            if (q.size() > 0) begin
                cur = q.pop_front();
                active = 1'b1;
                left = int'(cur.count) + 1;
            end else begin
                active = 1'b0;
            end
        end else begin
            left--;
        end
        if (push_now) q.push_back(nc);
        #1;
        check_outputs();
        accepted = push_now;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] data, input logic [3:0] count,
                        input logic serial, input logic stop);
        bit acc = 1'b0;
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = count;
        cmd_serial = serial; cmd_stop_on_flag = stop;
        while (!acc && n < 200) begin
            step(acc);
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $error("FAIL push_timeout observed=not_accepted expected=accepted");
        end
    endtask

    task automatic wait_idle();
        bit a;
        int n = 0;
        while ((active || q.size() > 0) && n < 400) begin
            step(a);
            n++;
        end
        if (active || q.size() > 0) begin
            checks++; failures++;
            $error("FAIL idle_timeout observed=busy expected=idle");
        end
        step(a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_operation", operation, 3'd5);
        chk("rst_in_data", in_data, 8'h00);
        chk("rst_shift", {in_shift_right, in_shift_left}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fill", fill, 3'd0);
        q.delete();
        active = 1'b0;
        left = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_ready", cmd_ready, 1'b1);
        check_outputs();
    endtask

    initial begin
        int d0;
        bit a;
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
        cmd_serial = 1'b0; cmd_stop_on_flag = 1'b0;
        reg_val = 8'h11;
        active = 1'b0; left = 0;
        rst_n = 1'b0;
        #12;
        do_reset();

        // load A4 then count_up x10 back-to-back
        d0 = done_seen;
        push(3'd0, 8'hA4, 4'd0, 1'b0, 1'b0);
        push(3'd6, 8'h00, 4'd9, 1'b0, 1'b0);
        wait_idle();
        chk("reg_after_count_up", reg_val, 8'hAE);
        chk("done_pulses", done_seen - d0, 2);

        // shift_right with serial 1 for 4 cycles
        push(3'd1, 8'h3C, 4'd3, 1'b1, 1'b0);
        wait_idle();
        chk("reg_after_shift", reg_val, 8'hFA);

        // fill the FIFO behind a long command
        push(3'd6, 8'h00, 4'd15, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            push(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        wait_idle();

        // early stop on flag: 02 -> 01 -> 00 (flag, last cycle) -> FF
        d0 = done_seen;
        push(3'd0, 8'h02, 4'd0, 1'b0, 1'b0);
        push(3'd7, 8'h00, 4'd15, 1'b0, 1'b1);
        wait_idle();
        chk("reg_after_stop", reg_val, 8'hFF);
        chk("stop_done_pulses", done_seen - d0, 2);

        // reset in the middle of ISSUE with commands queued
        push(3'd6, 8'h00, 4'd15, 1'b0, 1'b0);
        push(3'd0, 8'h55, 4'd2, 1'b0, 1'b0);
        push(3'd2, 8'h66, 4'd2, 1'b1, 1'b0);
        idle(2);
        do_reset();
        idle(6);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            push(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 6)),
                 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
